// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: operation and state encodings,
// the default memory depth and small classification helpers.
package lsu_pkg;

   // Number of words implemented in DataMemory.
   localparam int unsigned LSU_MEM_WORDS = 64;

   // Operation encoding presented by the execute stage.
   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_SW  = 3'd5,
      OP_SH  = 3'd6,
      OP_SB  = 3'd7
   } op_e;

   // Sequencer states; the encoding is also exported on the debug port.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic is_load(op_e op);
      return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
   endfunction

   function automatic logic is_store(op_e op);
      return op inside {OP_SW, OP_SH, OP_SB};
   endfunction

   // Sub-word stores need a read-modify-write of the containing word.
   function automatic logic is_partial(op_e op);
      return op inside {OP_SH, OP_SB};
   endfunction

   // Word ops need a 4-byte aligned address, halfword ops a 2-byte one;
   // byte ops can never be misaligned.
   function automatic logic is_misaligned(op_e op, logic [1:0] lsb);
      logic bad;
      bad = 1'b0;
      case (op)
         OP_LW, OP_SW:         bad = (lsb != 2'b00);
         OP_LH, OP_LHU, OP_SH: bad = lsb[0];
         default:              bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit. Lanes are little-endian:
// byte n of a word occupies bits [8n+7:8n].
//   load_value  : addressed byte/half of 'word', sign- or zero-extended
//   merged_word : 'word' with only the addressed lane replaced by store data
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  byte_sel,
   input  logic [2:0]  op,
   input  logic [15:0] store_data,
   output logic [31:0] load_value,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // Pick the addressed byte and halfword out of the memory word.
   always_comb begin
      byte_val = word[7:0];
      case (byte_sel)
         2'd0: byte_val = word[7:0];
         2'd1: byte_val = word[15:8];
         2'd2: byte_val = word[23:16];
         2'd3: byte_val = word[31:24];
         default: byte_val = word[7:0];
      endcase
      half_val = byte_sel[1] ? word[31:16] : word[15:0];
   end

   // Extend the selected lane to 32 bits according to the load type.
   always_comb begin
      load_value = word;
      case (op)
         OP_LW:   load_value = word;
         OP_LH:   load_value = {{16{half_val[15]}}, half_val};
         OP_LHU:  load_value = {16'h0000, half_val};
         OP_LB:   load_value = {{24{byte_val[7]}}, byte_val};
         OP_LBU:  load_value = {24'h000000, byte_val};
         default: load_value = word;
      endcase
   end

   // Overwrite only the addressed lane; every other bit passes through.
   always_comb begin
      merged_word = word;
      if (op == OP_SB) begin
         case (byte_sel)
            2'd0: merged_word[7:0]   = store_data[7:0];
            2'd1: merged_word[15:8]  = store_data[7:0];
            2'd2: merged_word[23:16] = store_data[7:0];
            2'd3: merged_word[31:24] = store_data[7:0];
            default: merged_word = word;
         endcase
      end else if (op == OP_SH) begin
         if (byte_sel[1]) merged_word[31:16] = store_data;
         else             merged_word[15:0]  = store_data;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of the word-only DataMemory. Takes one request
// at a time, checks alignment and range, then walks IDLE/READ/WAIT/WRITE/DONE
// to perform loads, full-word stores and read-modify-write sub-word stores.
// All outputs are registered.
//
// Handshake: a request (Op, Addr, StoreData) is accepted on the rising edge
// where ReqValid && ReqReady. ReqReady is 1 exactly while the unit is idle;
// the request is latched at that edge and the inputs are ignored until the
// unit is idle again. A rejected (misaligned/faulting) request is still
// consumed by the handshake, answered with a one-cycle error pulse, and the
// unit stays idle.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = LSU_MEM_WORDS
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic [2:0]  Op,
   input  logic [31:0] Addr,
   input  logic [31:0] StoreData,
   output logic [31:0] LoadData,
   output logic        LoadValid,
   output logic        StoreDone,
   output logic        Misaligned,
   output logic        AddrFault,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        MemoryRead,
   output logic        MemoryWrite,
   input  logic [31:0] MemReadData,
   output logic [2:0]  DebugState
);

   state_e      state;
   op_e         op_in;
   op_e         req_op;
   logic [1:0]  req_lsb;
   logic [15:0] req_data;
   logic        misaligned_now;
   logic        fault_now;
   logic [31:0] load_value;
   logic [31:0] merged_word;

   // Classify the incoming request before it is accepted.
   assign op_in          = op_e'(Op);
   assign misaligned_now = is_misaligned(op_in, Addr[1:0]);
   assign fault_now      = (Addr >> 2) >= 32'(MEM_WORDS);

   assign DebugState = state;

   // Lane extract/merge works on the latched request and the returning word.
   lsu_lane_align u_lane_align (
      .word        (MemReadData),
      .byte_sel    (req_lsb),
      .op          (req_op),
      .store_data  (req_data),
      .load_value  (load_value),
      .merged_word (merged_word)
   );

   // Sequencer FSM with request latch and registered memory/status outputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= ST_IDLE;
         req_op       <= OP_LW;
         req_lsb      <= 2'b00;
         req_data     <= 16'h0000;
         ReqReady     <= 1'b1;
         LoadData     <= 32'h0;
         LoadValid    <= 1'b0;
         StoreDone    <= 1'b0;
         Misaligned   <= 1'b0;
         AddrFault    <= 1'b0;
         MemAddress   <= 32'h0;
         MemWriteData <= 32'h0;
         MemoryRead   <= 1'b0;
         MemoryWrite  <= 1'b0;
      end else begin
         // Pulses and strobes default low; the states below raise them.
         LoadValid   <= 1'b0;
         StoreDone   <= 1'b0;
         Misaligned  <= 1'b0;
         AddrFault   <= 1'b0;
         MemoryRead  <= 1'b0;
         MemoryWrite <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ReqValid) begin
                  if (misaligned_now) begin
                     Misaligned <= 1'b1;
                  end else if (fault_now) begin
                     AddrFault <= 1'b1;
                  end else begin
                     req_op     <= op_in;
                     req_lsb    <= Addr[1:0];
                     req_data   <= StoreData[15:0];
                     MemAddress <= {Addr[31:2], 2'b00};
                     ReqReady   <= 1'b0;
                     if (is_store(op_in) && !is_partial(op_in)) begin
                        // Full word: no read needed, write straight away.
                        MemWriteData <= StoreData;
                        MemoryWrite  <= 1'b1;
                        StoreDone    <= 1'b1;
                        state        <= ST_WRITE;
                     end else begin
                        MemoryRead <= 1'b1;
                        state      <= ST_READ;
                     end
                  end
               end
            end
            ST_READ: begin
               // Read strobe was presented this cycle; data returns next cycle.
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (is_load(req_op)) begin
                  LoadData  <= load_value;
                  LoadValid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  MemWriteData <= merged_word;
                  MemoryWrite  <= 1'b1;
                  StoreDone    <= 1'b1;
                  state        <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               ReqReady <= 1'b1;
               state    <= ST_IDLE;
            end
            ST_DONE: begin
               ReqReady <= 1'b1;
               state    <= ST_IDLE;
            end
            default: begin
               ReqReady <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: drives requests into the unit, emulates the
// 64-word DataMemory behind it, and checks every response against a
// byte-addressed reference memory computed with plain arithmetic.
module tb_load_store_unit;

   localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                          OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;
   localparam int WORDS = 64;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        ReqValid;
   logic        ReqReady;
   logic [2:0]  Op;
   logic [31:0] Addr;
   logic [31:0] StoreData;
   logic [31:0] LoadData;
   logic        LoadValid;
   logic        StoreDone;
   logic        Misaligned;
   logic        AddrFault;
   logic [31:0] MemAddress;
   logic [31:0] MemWriteData;
   logic        MemoryRead;
   logic        MemoryWrite;
   logic [31:0] MemReadData;
   logic [2:0]  DebugState;

   int vectors = 0;
   int miscompares = 0;
   int overlap_cnt = 0;
   int idle_strobe_cnt = 0;

   logic [31:0] dmem    [WORDS];   // emulated DataMemory
   logic [31:0] ref_mem [WORDS];   // reference contents
   logic [31:0] exp_q [$];         // expected load results, in order

   load_store_unit dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .ReqValid     (ReqValid),
      .ReqReady     (ReqReady),
      .Op           (Op),
      .Addr         (Addr),
      .StoreData    (StoreData),
      .LoadData     (LoadData),
      .LoadValid    (LoadValid),
      .StoreDone    (StoreDone),
      .Misaligned   (Misaligned),
      .AddrFault    (AddrFault),
      .MemAddress   (MemAddress),
      .MemWriteData (MemWriteData),
      .MemoryRead   (MemoryRead),
      .MemoryWrite  (MemoryWrite),
      .MemReadData  (MemReadData),
      .DebugState   (DebugState)
   );

   // ---------------- clock / reset ----------------
   always #5 Clock = ~Clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DataMemory emulation ----------------
   always @(posedge Clock) begin
      if (MemoryRead)  MemReadData <= dmem[MemAddress[7:2]];
      if (MemoryWrite) dmem[MemAddress[7:2]] <= MemWriteData;
   end

   // Strobe sanity monitored every cycle.
   always @(negedge Clock) begin
      if (MemoryRead && MemoryWrite) overlap_cnt++;
      if (!Reset && ReqReady && (MemoryRead || MemoryWrite)) idle_strobe_cnt++;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [2:0] op);
      if (op == OP_LW || op == OP_SW) return 4;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
      return 1;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
      logic [31:0] w, b, h;
      int sh;
      w  = ref_mem[addr / 4];
      sh = 8 * int'(addr % 4);
      b  = (w >> sh) & 32'hFF;
      h  = (w >> sh) & 32'hFFFF;
      case (op)
         OP_LB:   return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
         OP_LBU:  return b;
         OP_LH:   return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
         OP_LHU:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_merge(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] data);
      logic [31:0] w, mask;
      int sh;
      w    = ref_mem[addr / 4];
      sh   = 8 * int'(addr % 4);
      mask = ((op == OP_SB) ? 32'hFF : 32'hFFFF) << sh;
      return (w & ~mask) | ((data << sh) & mask);
   endfunction

   // ---------------- driver ----------------
   // Issue one request from a negedge, then check the response cycle by cycle.
   task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
      int guard;
      int size;
      logic mis, flt;
      logic [31:0] exp_w;
      guard = 0;
      while (!ReqReady && guard < 50) begin
         @(negedge Clock);
         guard++;
      end
      check("ready_before_req", {31'd0, ReqReady}, 32'd1);
      if (!ReqReady) return;
      size = op_size(op);
      mis  = (addr % size) != 0;
      flt  = !mis && ((addr / 4) >= WORDS);
      ReqValid = 1'b1; Op = op; Addr = addr; StoreData = data;
      @(posedge Clock);
      #1;
      // Junk on the inputs while busy must not disturb the latched request.
      ReqValid = 1'b0; Op = 3'($urandom_range(0, 7)); Addr = $urandom; StoreData = $urandom;
      @(negedge Clock);
      if (mis || flt) begin
         check("err_misaligned", {31'd0, Misaligned}, {31'd0, mis});
         check("err_fault", {31'd0, AddrFault}, {31'd0, flt});
         check("err_no_access", {30'd0, MemoryRead, MemoryWrite}, 32'd0);
         check("err_ready", {31'd0, ReqReady}, 32'd1);
         return;
      end
      check("mem_address", MemAddress, addr & 32'hFFFFFFFC);
      if (op == OP_SW) begin
         check("sw_write", {30'd0, MemoryWrite, StoreDone}, 32'd3);
         check("sw_data", MemWriteData, data);
         ref_mem[addr / 4] = data;
         @(negedge Clock);
         check("sw_ready_after", {30'd0, ReqReady, MemoryWrite}, 32'd2);
         return;
      end
      check("rd_strobe", {30'd0, MemoryRead, MemoryWrite}, 32'd2);
      @(negedge Clock);
      check("wait_quiet", {29'd0, MemoryRead, MemoryWrite, LoadValid}, 32'd0);
      @(negedge Clock);
      check("addr_stable", MemAddress, addr & 32'hFFFFFFFC);
      if (op == OP_SH || op == OP_SB) begin
         exp_w = ref_merge(op, addr, data);
         check("rmw_write", {29'd0, MemoryWrite, StoreDone, MemoryRead}, 32'd6);
         check("rmw_data", MemWriteData, exp_w);
         ref_mem[addr / 4] = exp_w;
      end else begin
         exp_q.push_back(ref_load(op, addr));
         check("load_valid", {31'd0, LoadValid}, 32'd1);
         check("load_data", LoadData, exp_q.pop_front());
      end
      @(negedge Clock);
      check("ready_after", {30'd0, ReqReady, LoadValid}, 32'd2);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic [2:0]  s_op   [3];
      logic [31:0] s_addr [3];
      logic [31:0] s_data [3];
      int idx, cyc, loads_seen, stores_seen, bad_words;

      for (int i = 0; i < WORDS; i++) begin
         ref_mem[i] = $urandom;
         dmem[i] <= ref_mem[i];
      end
      Reset = 1'b1; ReqValid = 1'b0; Op = 3'd0; Addr = 32'd0; StoreData = 32'd0;
      repeat (3) @(negedge Clock);
      check("reset_ready", {31'd0, ReqReady}, 32'd1);
      check("reset_pulses", {26'd0, LoadValid, StoreDone, Misaligned, AddrFault, MemoryRead, MemoryWrite}, 32'd0);
      check("reset_mem_address", MemAddress, 32'd0);
      check("reset_write_data", MemWriteData, 32'd0);
      check("reset_load_data", LoadData, 32'd0);
      Reset = 1'b0;
      @(negedge Clock);

      // Basic word store/load and sub-word loads.
      run_req(OP_SW, 32'h10, 32'hDEADBEEF);
      run_req(OP_LW, 32'h10, 32'h0);
      run_req(OP_LB, 32'h11, 32'h0);
      run_req(OP_LBU, 32'h11, 32'h0);
      run_req(OP_LH, 32'h12, 32'h0);
      run_req(OP_LHU, 32'h10, 32'h0);
      // Read-modify-write stores.
      run_req(OP_SB, 32'h13, 32'h12);
      run_req(OP_SH, 32'h10, 32'h5555);
      run_req(OP_LW, 32'h10, 32'h0);
      // Error cases and range boundaries.
      run_req(OP_LW, 32'h02, 32'h0);
      run_req(OP_SH, 32'h11, 32'h0);
      run_req(OP_LW, 32'h100, 32'h0);
      run_req(OP_LB, 32'h101, 32'h0);
      run_req(OP_SW, 32'hFC, 32'hA5A55A5A);
      run_req(OP_LBU, 32'hFF, 32'h0);

      // Reset while an SB sits in WAIT: the write must never happen.
      ReqValid = 1'b1; Op = OP_SB; Addr = 32'h10; StoreData = 32'h77;
      @(posedge Clock);
      #1 ReqValid = 1'b0;
      @(negedge Clock);
      check("abort_read", {31'd0, MemoryRead}, 32'd1);
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      check("abort_idle", {30'd0, ReqReady, MemoryWrite}, 32'd2);
      Reset = 1'b0;
      repeat (3) begin
         @(negedge Clock);
         check("abort_no_write", {30'd0, MemoryWrite, StoreDone}, 32'd0);
      end
      run_req(OP_LW, 32'h10, 32'h0);

      // ReqValid held high across LW, LW, SW.
      s_op[0] = OP_LW; s_addr[0] = 32'h20; s_data[0] = 32'h0;
      s_op[1] = OP_LW; s_addr[1] = 32'h24; s_data[1] = 32'h0;
      s_op[2] = OP_SW; s_addr[2] = 32'h20; s_data[2] = $urandom;
      idx = 0; cyc = 0; loads_seen = 0; stores_seen = 0;
      while ((idx < 3 || loads_seen < 2 || stores_seen < 1) && cyc < 60) begin
         if (LoadValid) begin
            if (exp_q.size() > 0) check("stream_load", LoadData, exp_q.pop_front());
            else check("stream_extra_load", {31'd0, LoadValid}, 32'd0);
            loads_seen++;
         end
         if (StoreDone) begin
            check("stream_store", MemWriteData, s_data[2]);
            stores_seen++;
         end
         if (idx < 3) begin
            ReqValid = 1'b1; Op = s_op[idx]; Addr = s_addr[idx]; StoreData = s_data[idx];
         end else begin
            ReqValid = 1'b0;
         end
         if (ReqValid && ReqReady) begin
            if (s_op[idx] == OP_SW) ref_mem[s_addr[idx] / 4] = s_data[idx];
            else exp_q.push_back(ref_load(s_op[idx], s_addr[idx]));
            idx++;
         end
         @(negedge Clock);
         cyc++;
      end
      ReqValid = 1'b0;
      check("stream_complete", {29'd0, idx == 3, loads_seen == 2, stores_seen == 1}, 32'd7);
      run_req(OP_LW, 32'h20, 32'h0);

      // Randomized traffic, mostly legal with some misaligned/out-of-range.
      for (int n = 0; n < 200; n++) begin
         logic [2:0]  op;
         logic [31:0] a;
         int sz, r;
         op = 3'($urandom_range(0, 7));
         sz = op_size(op);
         r  = $urandom_range(0, 19);
         if (r == 0)      a = 32'($urandom_range(64, 300) * 4 + ($urandom_range(0, 3) / sz) * sz);
         else if (r == 1) a = 32'($urandom_range(0, 255));
         else             a = 32'($urandom_range(0, WORDS - 1) * 4 + ($urandom_range(0, 3) / sz) * sz);
         run_req(op, a, $urandom);
      end

      // Final state of memory and strobe monitors.
      bad_words = 0;
      for (int i = 0; i < WORDS; i++) if (dmem[i] !== ref_mem[i]) bad_words++;
      check("mem_image", 32'(bad_words), 32'd0);
      check("rw_overlap", 32'(overlap_cnt), 32'd0);
      check("idle_strobes", 32'(idle_strobe_cnt), 32'd0);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
